// File: rtl/mux16_scan_ctrl.sv
// mux16_scan_ctrl: round-robin scanner driving a 16:1 mux select and streaming (channel, sample) pairs.
module mux16_scan_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic [15:0]      ch_mask,
    input  logic [WIDTH-1:0] y,
    output logic [2:0]       s1,
    output logic             s0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_ch,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;
    localparam logic [3:0] LAST = 4'(SETTLE - 1);
    state_t      state;
    logic [15:0] mask;
    logic [15:0] above;
    logic [3:0]  cnt;
    function automatic logic [3:0] lowest(input logic [15:0] v);
        lowest = '0;
        for (int i = 15; i >= 0; i--)
            if (v[i]) lowest = i[3:0];
    endfunction
    // 16-bit overflow of 2<<15 yields an empty window above channel 15
    assign above = mask & ~((16'd2 << {s1, s0}) - 16'd1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mask      <= '0;
            cnt       <= '0;
            {s1, s0}  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    mask <= ch_mask;
                    if (ch_mask == '0) done <= 1'b1;
                    else begin
                        {s1, s0} <= lowest(ch_mask);
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= S_SETTLE;
                    end
                end
                S_SETTLE: if (cnt == LAST) begin
                    out_data  <= y;
                    out_ch    <= {s1, s0};
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end else cnt <= cnt + 4'd1;
                S_HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    cnt       <= '0;
                    if (above != '0) begin
                        {s1, s0} <= lowest(above);
                        state    <= S_SETTLE;
                    end else if (cont) begin
                        {s1, s0} <= lowest(mask);
                        state    <= S_SETTLE;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
